// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cancel,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, next_state;
    logic [CW-1:0]          count, next_count;
    logic [2*WIDTH-1:0]     pending, next_pending;
    logic                   pending_we, next_pending_we;
    logic [WIDTH-1:0]       next_hi, next_lo;
    logic                   next_done;

    logic                   accept;
    logic                   is_multi;
    logic                   is_div;
    logic                   div_zero;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     rs_sx, rt_sx, rs_zx, rt_zx;
    logic [2*WIDTH-1:0]     prod_s, prod_u;
    logic [WIDTH-1:0]       divisor, abs_a, abs_b;
    logic [WIDTH-1:0]       uq, ur, mq, mr, sq, sr;
    logic [2*WIDTH-1:0]     result;
    logic                   result_we;

    assign busy     = (state == RUN);
    assign is_multi = (op >= OP_MULT) && (op <= OP_MSUBU);
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign accept   = op_valid && !busy && !cancel && (op >= OP_MULT) && (op <= OP_MTLO);
    assign start    = accept && is_multi;

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        acc    = {hi, lo};
        rs_sx  = {{WIDTH{rs[WIDTH-1]}}, rs};
        rt_sx  = {{WIDTH{rt[WIDTH-1]}}, rt};
        rs_zx  = {{WIDTH{1'b0}}, rs};
        rt_zx  = {{WIDTH{1'b0}}, rt};
        prod_s = rs_sx * rt_sx;
        prod_u = rs_zx * rt_zx;
    end

    // Signed divide via magnitudes; the most-negative / -1 case falls out as lo=rs, hi=0.
    always_comb begin
        div_zero = (rt == '0);
        divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : rt;
        abs_a    = rs[WIDTH-1] ? -rs : rs;
        abs_b    = divisor[WIDTH-1] ? -divisor : divisor;
        uq       = rs / divisor;
        ur       = rs % divisor;
        mq       = abs_a / abs_b;
        mr       = abs_a % abs_b;
        sq       = (rs[WIDTH-1] ^ divisor[WIDTH-1]) ? -mq : mq;
        sr       = rs[WIDTH-1] ? -mr : mr;
    end

    always_comb begin
        result    = acc;
        result_we = !(is_div && div_zero);
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {sr, sq};
            OP_DIVU:  result = {ur, uq};
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            OP_MSUB:  result = acc - prod_s;
            OP_MSUBU: result = acc - prod_u;
            default:  result = acc;
        endcase
    end

    always_comb begin
        next_state      = state;
        next_count      = count;
        next_pending    = pending;
        next_pending_we = pending_we;
        next_hi         = hi;
        next_lo         = lo;
        next_done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state      = RUN;
                    next_count      = is_div ? DIV_LOAD : MULT_LOAD;
                    next_pending    = result;
                    next_pending_we = result_we;
                end else if (accept && op == OP_MTHI) begin
                    next_hi = rs;
                end else if (accept && op == OP_MTLO) begin
                    next_lo = rs;
                end
            end
            RUN: begin
                if (cancel) begin
                    next_state      = IDLE;
                    next_count      = '0;
                    next_pending    = '0;
                    next_pending_we = 1'b0;
                end else if (count == '0) begin
                    next_state      = IDLE;
                    next_done       = 1'b1;
                    next_pending    = '0;
                    next_pending_we = 1'b0;
                    if (pending_we) begin
                        next_hi = pending[2*WIDTH-1:WIDTH];
                        next_lo = pending[WIDTH-1:0];
                    end
                end else begin
                    next_count = count - 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            pending    <= '0;
            pending_we <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            pending    <= next_pending;
            pending_we <= next_pending_we;
            hi         <= next_hi;
            lo         <= next_lo;
            done       <= next_done;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        cancel;
    logic        start, busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
        .cancel(cancel), .start(start), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_now(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic st);
        op_valid = 1'b1; op = o; rs = a; rt = b;
        #1 st = start;
        @(posedge clk);
        #1 op_valid = 1'b0; op = 4'd0;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic st);
        @(negedge clk);
        drive_now(o, a, b, st);
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        logic st;
        drive(4'd9, h, 32'd0, st);
        drive(4'd10, l, 32'd0, st);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic st;
        int n, busy_cnt, done_cnt, done_at;
        string tag;
        tag = $sformatf("vec%0d", idx);
        n = (v.op == 4'd3 || v.op == 4'd4) ? 10 : 5;
        set_hilo(v.pre_hi, v.pre_lo);
        drive(v.op, v.rs, v.rt, st);
        check({tag, " start"}, 64'(st), 64'd1);
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int c = 1; c <= n + 4; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(n));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " done_cycle"}, 64'(done_at), 64'(n + 1));
        check({tag, " hi"}, 64'(hi), 64'(v.exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(v.exp_lo));
    endtask

    initial begin
        logic st;
        int busy_cnt, done_cnt;
        bit got_done;

        //              op    rs            rt            pre_hi        pre_lo        exp_hi        exp_lo
        vecs[0]  = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd4, 32'd7,        32'd2,        32'h0,        32'h0,        32'd1,        32'd3};
        vecs[4]  = '{4'd4, 32'd9,        32'd0,        32'h1234,     32'h5678,     32'h1234,     32'h5678};
        vecs[5]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h11,       32'h22,       32'h0,        32'h80000000};
        vecs[6]  = '{4'd6, 32'd1,        32'd1,        32'h0,        32'hFFFFFFFF, 32'd1,        32'd0};
        vecs[7]  = '{4'd7, 32'd1,        32'd2,        32'd1,        32'd0,        32'd0,        32'hFFFFFFFE};
        vecs[8]  = '{4'd5, 32'hFFFFFFFF, 32'd3,        32'd0,        32'd5,        32'd0,        32'd2};
        vecs[9]  = '{4'd8, 32'd1,        32'd1,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[10] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'd1,        32'hFFFFFFFD};
        vecs[11] = '{4'd3, 32'd5,        32'd0,        32'hAA,       32'hBB,       32'hAA,       32'hBB};

        reset = 1'b1; op_valid = 1'b0; op = 4'd0; rs = '0; rt = '0; cancel = 1'b0;
        #12;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // MULT offered while busy is dropped
        set_hilo(32'd0, 32'd0);
        drive(4'd1, 32'd3, 32'd4, st);
        @(negedge clk);
        @(negedge clk);
        op_valid = 1'b1; op = 4'd1; rs = 32'd100; rt = 32'd100;
        #1 check("busy_ignore start", 64'(start), 64'd0);
        @(posedge clk);
        #1 op_valid = 1'b0; op = 4'd0;
        repeat (8) @(negedge clk);
        check("busy_ignore busy", 64'(busy), 64'd0);
        check("busy_ignore hi", 64'(hi), 64'd0);
        check("busy_ignore lo", 64'(lo), 64'd12);

        // cancel in busy cycle 3, then on the commit cycle (busy cycle 5)
        for (int k = 0; k < 2; k++) begin
            set_hilo(32'hA, 32'hB);
            drive(4'd1, 32'd3, 32'd4, st);
            repeat (k == 0 ? 3 : 5) @(negedge clk);
            cancel = 1'b1;
            @(posedge clk);
            #1 cancel = 1'b0;
            check($sformatf("cancel%0d busy_after", k), 64'(busy), 64'd0);
            done_cnt = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            check($sformatf("cancel%0d done", k), 64'(done_cnt), 64'd0);
            check($sformatf("cancel%0d hi", k), 64'(hi), 64'hA);
            check($sformatf("cancel%0d lo", k), 64'(lo), 64'hB);
        end

        // cancel while idle blocks acceptance
        @(negedge clk);
        cancel = 1'b1; op_valid = 1'b1; op = 4'd1; rs = 32'd2; rt = 32'd2;
        #1 check("idle_cancel start", 64'(start), 64'd0);
        @(posedge clk);
        #1 check("idle_cancel busy", 64'(busy), 64'd0);
        cancel = 1'b0; op_valid = 1'b0; op = 4'd0;

        // back-to-back: MADDU issued in the done cycle sees the fresh product
        set_hilo(32'd0, 32'd3);
        drive(4'd2, 32'd2, 32'd3, st);
        got_done = 1'b0;
        for (int c = 0; c < 20 && !got_done; c++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        check("b2b done_seen", 64'(got_done), 64'd1);
        drive_now(4'd6, 32'd1, 32'd1, st);
        check("b2b start", 64'(st), 64'd1);
        repeat (8) @(negedge clk);
        check("b2b hi", 64'(hi), 64'd0);
        check("b2b lo", 64'(lo), 64'd7);

        // asynchronous reset mid-DIV
        set_hilo(32'h11, 32'h22);
        drive(4'd3, 32'd100, 32'd7, st);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset busy", 64'(busy), 64'd0);
        check("areset done", 64'(done), 64'd0);
        check("areset hi", 64'(hi), 64'd0);
        check("areset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("areset post_busy", 64'(busy_cnt), 64'd0);
        check("areset post_done", 64'(done_cnt), 64'd0);
        check("areset post_hi", 64'(hi), 64'd0);
        check("areset post_lo", 64'(lo), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
